// File: rtl/uart_receiver.sv
// uart_receiver
//   Oversampling UART receiver. The asynchronous line passes through a
//   two-flop synchronizer and is sampled once per bit at mid-bit. The
//   receiver deframes start, data (LSB first), optional parity and stop
//   bits. Each completed character produces a one-cycle valid_o pulse
//   together with its data and error flags.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   enable_i       permits detection of new start bits
//   rx_i           asynchronous serial input, idle high
//   data_o         last received character
//   valid_o        one-cycle pulse per completed frame
//   parity_error_o parity mismatch on last frame
//   frame_error_o  a stop bit sampled low on last frame
//   busy_o         frame reception in progress
module uart_receiver #(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE       = 115_200,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned STOP_BITS       = 1,
  parameter bit          PARITY_ENABLE   = 1'b0,
  parameter              PARITY_TYPE     = "even"
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  parity_error_o,
  output logic                  frame_error_o,
  output logic                  busy_o
);

  localparam int unsigned DIV  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);
  localparam bit          PARITY_ODD = (PARITY_TYPE != "even");

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                state;
  logic [1:0]            sync;
  logic                  rx_s;
  logic [CW-1:0]         cnt;
  logic [3:0]            bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  perr_acc;
  logic                  fe_acc;
  logic                  exp_parity;

  assign rx_s       = sync[1];
  assign exp_parity = PARITY_ODD ? ~^shreg : ^shreg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= ST_IDLE;
      sync           <= '1;
      cnt            <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= 1'b0;
      shreg          <= '0;
      perr_acc       <= 1'b0;
      fe_acc         <= 1'b0;
      data_o         <= '0;
      valid_o        <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      sync    <= {sync[0], rx_i};
      valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (enable_i && !rx_s) begin
            state    <= ST_START;
            busy_o   <= 1'b1;
            perr_acc <= 1'b0;
            fe_acc   <= 1'b0;
          end
        end

        ST_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              // Glitch rather than a start bit: drop it silently.
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
              state    <= PARITY_ENABLE ? ST_PARITY : ST_STOP;
              stop_cnt <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_PARITY: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt      <= '0;
            perr_acc <= (rx_s != exp_parity);
            state    <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_STOP: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            if (!rx_s) fe_acc <= 1'b1;
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              // Current sample folded in directly since fe_acc updates late.
              state          <= ST_IDLE;
              busy_o         <= 1'b0;
              valid_o        <= 1'b1;
              data_o         <= shreg;
              parity_error_o <= PARITY_ENABLE && perr_acc;
              frame_error_o  <= fe_acc | ~rx_s;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        pe;
    logic        fe;
  } ev_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic enable_i = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic [7:0] data_a, data_b, data_c;
  logic valid_a, valid_b, valid_c;
  logic pe_a, pe_b, pe_c;
  logic fe_a, fe_b, fe_c;
  logic busy_a, busy_b, busy_c;

  int unsigned cyc = 0;
  int unsigned busy_cnt_a = 0;
  ev_t q_a[$], q_b[$], q_c[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8N1, 16 cycles per bit
  uart_receiver #(.CLOCK_FREQUENCY(1_600_000), .BAUD_RATE(100_000)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .rx_i(rx_a),
    .data_o(data_a), .valid_o(valid_a), .parity_error_o(pe_a),
    .frame_error_o(fe_a), .busy_o(busy_a));

  // 8E1
  uart_receiver #(.CLOCK_FREQUENCY(1_600_000), .BAUD_RATE(100_000),
                  .PARITY_ENABLE(1'b1), .PARITY_TYPE("even")) dut_b (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .rx_i(rx_b),
    .data_o(data_b), .valid_o(valid_b), .parity_error_o(pe_b),
    .frame_error_o(fe_b), .busy_o(busy_b));

  // 8N2
  uart_receiver #(.CLOCK_FREQUENCY(1_600_000), .BAUD_RATE(100_000),
                  .STOP_BITS(2)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .rx_i(rx_c),
    .data_o(data_c), .valid_o(valid_c), .parity_error_o(pe_c),
    .frame_error_o(fe_c), .busy_o(busy_c));

  always @(negedge clk) begin
    if (valid_a === 1'b1) q_a.push_back('{cyc: cyc, data: data_a, pe: pe_a, fe: fe_a});
    if (valid_b === 1'b1) q_b.push_back('{cyc: cyc, data: data_b, pe: pe_b, fe: fe_b});
    if (valid_c === 1'b1) q_c.push_back('{cyc: cyc, data: data_c, pe: pe_c, fe: fe_c});
    if (busy_a === 1'b1) busy_cnt_a++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic b, input int n);
    case (sel)
      0: rx_a = b;
      1: rx_b = b;
      default: rx_c = b;
    endcase
    wait_cycles(n);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit par_en,
                            input logic par_bit, input logic [1:0] stops, input int nstop);
    drive(sel, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(sel, d[i], 16);
    if (par_en) drive(sel, par_bit, 16);
    for (int i = 0; i < nstop; i++) drive(sel, stops[i], 16);
    drive(sel, 1'b1, 0);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    wait_cycles(3);
    checks++;
    if ({data_a, valid_a, pe_a, fe_a, busy_a} !== 12'h000) begin
      errors++; $display("FAIL reset_a got %h expected 000", {data_a, valid_a, pe_a, fe_a, busy_a});
    end
    checks++;
    if ({data_b, valid_b, pe_b, fe_b, busy_b} !== 12'h000) begin
      errors++; $display("FAIL reset_b got %h expected 000", {data_b, valid_b, pe_b, fe_b, busy_b});
    end
    checks++;
    if ({data_c, valid_c, pe_c, fe_c, busy_c} !== 12'h000) begin
      errors++; $display("FAIL reset_c got %h expected 000", {data_c, valid_c, pe_c, fe_c, busy_c});
    end
    reset_i = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_clean_frame();
    int n0;
    int unsigned fall;
    n0 = q_a.size();
    busy_cnt_a = 0;
    fall = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1);
    wait_cycles(20);
    checks++;
    if (q_a.size() != n0 + 1) begin
      errors++; $display("FAIL clean_count got %0d expected %0d", q_a.size() - n0, 1);
    end else begin
      checks++;
      if (q_a[n0].cyc - fall != 155) begin
        errors++; $display("FAIL clean_latency got %0d expected 155", q_a[n0].cyc - fall);
      end
      checks++;
      if (q_a[n0].data !== 8'hA5) begin
        errors++; $display("FAIL clean_data got %h expected a5", q_a[n0].data);
      end
      checks++;
      if ({q_a[n0].pe, q_a[n0].fe} !== 2'b00) begin
        errors++; $display("FAIL clean_flags got %b expected 00", {q_a[n0].pe, q_a[n0].fe});
      end
    end
    checks++;
    if (busy_cnt_a != 152) begin
      errors++; $display("FAIL clean_busy_cycles got %0d expected 152", busy_cnt_a);
    end
  endtask

  task automatic test_parity();
    int n0;
    n0 = q_b.size();
    send_frame(1, 8'h03, 1'b1, 1'b0, 2'b11, 1);
    wait_cycles(20);
    send_frame(1, 8'h03, 1'b1, 1'b1, 2'b11, 1);
    wait_cycles(20);
    checks++;
    if (q_b.size() != n0 + 2) begin
      errors++; $display("FAIL parity_count got %0d expected 2", q_b.size() - n0);
    end else begin
      checks++;
      if ({q_b[n0].data, q_b[n0].pe, q_b[n0].fe} !== {8'h03, 2'b00}) begin
        errors++; $display("FAIL parity_good got %h/%b%b expected 03/00",
                           q_b[n0].data, q_b[n0].pe, q_b[n0].fe);
      end
      checks++;
      if ({q_b[n0+1].data, q_b[n0+1].pe, q_b[n0+1].fe} !== {8'h03, 2'b10}) begin
        errors++; $display("FAIL parity_bad got %h/%b%b expected 03/10",
                           q_b[n0+1].data, q_b[n0+1].pe, q_b[n0+1].fe);
      end
    end
  endtask

  task automatic test_frame_error();
    int n0;
    n0 = q_c.size();
    // stops[0]=1, stops[1]=0: second stop bit low
    send_frame(2, 8'h81, 1'b0, 1'b0, 2'b01, 2);
    wait_cycles(40);
    send_frame(2, 8'h5A, 1'b0, 1'b0, 2'b11, 2);
    wait_cycles(20);
    checks++;
    if (q_c.size() != n0 + 2) begin
      errors++; $display("FAIL frame_count got %0d expected 2", q_c.size() - n0);
    end else begin
      checks++;
      if ({q_c[n0].data, q_c[n0].pe, q_c[n0].fe} !== {8'h81, 2'b01}) begin
        errors++; $display("FAIL frame_err got %h/%b%b expected 81/01",
                           q_c[n0].data, q_c[n0].pe, q_c[n0].fe);
      end
      checks++;
      if ({q_c[n0+1].data, q_c[n0+1].pe, q_c[n0+1].fe} !== {8'h5A, 2'b00}) begin
        errors++; $display("FAIL frame_clean got %h/%b%b expected 5a/00",
                           q_c[n0+1].data, q_c[n0+1].pe, q_c[n0+1].fe);
      end
    end
  endtask

  task automatic test_false_start();
    int n0;
    n0 = q_a.size();
    busy_cnt_a = 0;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    checks++;
    if (q_a.size() != n0) begin
      errors++; $display("FAIL false_start_valid got %0d expected 0", q_a.size() - n0);
    end
    checks++;
    if (busy_cnt_a != 8) begin
      errors++; $display("FAIL false_start_busy got %0d expected 8", busy_cnt_a);
    end
    checks++;
    if ({data_a, pe_a, fe_a, busy_a} !== {8'hA5, 3'b000}) begin
      errors++; $display("FAIL false_start_hold got %h expected a50", {data_a, pe_a, fe_a, busy_a});
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    int unsigned fall;
    n0 = q_a.size();
    fall = cyc;
    send_frame(0, 8'h00, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 2'b11, 1);
    wait_cycles(20);
    checks++;
    if (q_a.size() != n0 + 2) begin
      errors++; $display("FAIL b2b_count got %0d expected 2", q_a.size() - n0);
    end else begin
      checks++;
      if (q_a[n0].cyc - fall != 155) begin
        errors++; $display("FAIL b2b_first_latency got %0d expected 155", q_a[n0].cyc - fall);
      end
      checks++;
      if (q_a[n0+1].cyc - q_a[n0].cyc != 160) begin
        errors++; $display("FAIL b2b_spacing got %0d expected 160", q_a[n0+1].cyc - q_a[n0].cyc);
      end
      checks++;
      if ({q_a[n0].data, q_a[n0].pe, q_a[n0].fe} !== {8'h00, 2'b00}) begin
        errors++; $display("FAIL b2b_first got %h/%b%b expected 00/00",
                           q_a[n0].data, q_a[n0].pe, q_a[n0].fe);
      end
      checks++;
      if ({q_a[n0+1].data, q_a[n0+1].pe, q_a[n0+1].fe} !== {8'hFF, 2'b00}) begin
        errors++; $display("FAIL b2b_second got %h/%b%b expected ff/00",
                           q_a[n0+1].data, q_a[n0+1].pe, q_a[n0+1].fe);
      end
    end
  endtask

  task automatic test_reset_enable();
    int n0;
    logic [7:0] d;
    d = 8'hC3;
    n0 = q_a.size();
    drive(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive(0, d[i], 16);
    drive(0, d[3], 8);
    reset_i = 1'b1;
    wait_cycles(1);
    reset_i = 1'b0;
    rx_a = 1'b1;
    checks++;
    if ({data_a, valid_a, pe_a, fe_a, busy_a} !== 12'h000) begin
      errors++; $display("FAIL midframe_reset got %h expected 000", {data_a, valid_a, pe_a, fe_a, busy_a});
    end
    wait_cycles(40);
    checks++;
    if (q_a.size() != n0) begin
      errors++; $display("FAIL midframe_no_valid got %0d expected 0", q_a.size() - n0);
    end
    send_frame(0, 8'h3C, 1'b0, 1'b0, 2'b11, 1);
    wait_cycles(20);
    checks++;
    if (q_a.size() != n0 + 1) begin
      errors++; $display("FAIL after_reset_count got %0d expected 1", q_a.size() - n0);
    end else begin
      checks++;
      if ({q_a[n0].data, q_a[n0].pe, q_a[n0].fe} !== {8'h3C, 2'b00}) begin
        errors++; $display("FAIL after_reset_data got %h/%b%b expected 3c/00",
                           q_a[n0].data, q_a[n0].pe, q_a[n0].fe);
      end
    end

    n0 = q_a.size();
    enable_i = 1'b0;
    busy_cnt_a = 0;
    send_frame(0, 8'h77, 1'b0, 1'b0, 2'b11, 1);
    wait_cycles(20);
    enable_i = 1'b1;
    wait_cycles(5);
    checks++;
    if (q_a.size() != n0) begin
      errors++; $display("FAIL disabled_valid got %0d expected 0", q_a.size() - n0);
    end
    checks++;
    if (busy_cnt_a != 0) begin
      errors++; $display("FAIL disabled_busy got %0d expected 0", busy_cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_parity();
    test_frame_error();
    test_false_start();
    test_back_to_back();
    test_reset_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
